mips_mem_arbiter: RTL

- Round-robin arbiter that shares the single AXI-Lite memory master port of the MIPS CPU between NUM_REQ internal requesters (e.g. instruction fetch, load/store unit, DMA/debug).
- Each requester uses a simple valid/ready request interface.
- The block sequences one AXI-Lite transaction at a time (read: AR then R; write: AW+W then B) and routes the response back to the granted requester.
- Sits between the requester logic in the core and the memory AXI-Lite port leaving the CPU top.

---
 rtl/mips_mem_arbiter.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/mips_mem_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite master port among NUM_REQ requesters.
// Optional per-requester wait counters when MIPS_MEM_ARB_PERF_EN is defined.
module mips_mem_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32
) (
  input  logic                      mips_cpu_clk,
  input  logic                      mips_axi_if_resetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]     req_wdata,
  input  logic [NUM_REQ*4-1:0]      req_wstrb,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [31:0]               resp_rdata,
  output logic                      resp_err,
  output logic [ADDR_W-1:0]         axi_araddr,
  output logic                      axi_arvalid,
  input  logic                      axi_arready,
  input  logic [31:0]               axi_rdata,
  input  logic [1:0]                axi_rresp,
  input  logic                      axi_rvalid,
  output logic                      axi_rready,
  output logic [ADDR_W-1:0]         axi_awaddr,
  output logic                      axi_awvalid,
  input  logic                      axi_awready,
  output logic [31:0]               axi_wdata,
  output logic [3:0]                axi_wstrb,
  output logic                      axi_wvalid,
  input  logic                      axi_wready,
  input  logic [1:0]                axi_bresp,
  input  logic                      axi_bvalid,
  output logic                      axi_bready
`ifdef MIPS_MEM_ARB_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0]     arb_wait_cnt
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_REQ,
    S_WR_RESP
  } state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [IDX_W-1:0]     gnt_q;
  logic [NUM_REQ-1:0]   resp_valid_q;
  logic [31:0]          resp_rdata_q;
  logic                 resp_err_q;
  logic [ADDR_W-1:0]    araddr_q;
  logic                 arvalid_q;
  logic                 rready_q;
  logic [ADDR_W-1:0]    awaddr_q;
  logic                 awvalid_q;
  logic [31:0]          wdata_q;
  logic [3:0]           wstrb_q;
  logic                 wvalid_q;
  logic                 bready_q;
  logic                 aw_done_q;
  logic                 w_done_q;

  logic                 grant_found;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W:0]       cand;
  logic [NUM_REQ-1:0]   grant_oh;
  logic [IDX_W-1:0]     rr_ptr_d;
  logic                 aw_hs;
  logic                 w_hs;

  // Search from rr_ptr upward with wrap-around; first pending requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!grant_found && req_valid[cand[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    if (grant_found) begin
      grant_oh = NUM_REQ'(1) << grant_idx;
    end
  end

  always_comb begin
    if (grant_idx == IDX_W'(NUM_REQ - 1)) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = grant_idx + IDX_W'(1);
    end
  end

  // The acceptance pulse is combinational so the requester sees it in the grant cycle.
  assign req_ready = (state_q == S_IDLE && mips_axi_if_resetn) ? grant_oh : '0;

  assign aw_hs = awvalid_q && axi_awready;
  assign w_hs  = wvalid_q && axi_wready;

  always_ff @(posedge mips_cpu_clk or negedge mips_axi_if_resetn) begin
    if (!mips_axi_if_resetn) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      gnt_q        <= '0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      araddr_q     <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awaddr_q     <= '0;
      awvalid_q    <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      resp_valid_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (grant_found) begin
            gnt_q    <= grant_idx;
            rr_ptr_q <= rr_ptr_d;
            if (req_we[grant_idx]) begin
              awaddr_q  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
              wdata_q   <= req_wdata[grant_idx*32 +: 32];
              wstrb_q   <= req_wstrb[grant_idx*4 +: 4];
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= S_WR_REQ;
            end else begin
              araddr_q  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
              arvalid_q <= 1'b1;
              state_q   <= S_RD_ADDR;
            end
          end
        end
        S_RD_ADDR: begin
          if (axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (axi_rvalid) begin
            rready_q     <= 1'b0;
            resp_valid_q <= NUM_REQ'(1) << gnt_q;
            resp_rdata_q <= axi_rdata;
            resp_err_q   <= |axi_rresp;
            state_q      <= S_IDLE;
          end
        end
        S_WR_REQ: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          // AW and W may complete in either order or together.
          if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
            bready_q <= 1'b1;
            state_q  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (axi_bvalid) begin
            bready_q     <= 1'b0;
            resp_valid_q <= NUM_REQ'(1) << gnt_q;
            resp_err_q   <= |axi_bresp;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;
  assign axi_araddr  = araddr_q;
  assign axi_arvalid = arvalid_q;
  assign axi_rready  = rready_q;
  assign axi_awaddr  = awaddr_q;
  assign axi_awvalid = awvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_wvalid  = wvalid_q;
  assign axi_bready  = bready_q;

`ifdef MIPS_MEM_ARB_PERF_EN
  logic [NUM_REQ*32-1:0] wait_cnt_q;

  // Counts cycles a requester is pending but not accepted; wraps naturally.
  always_ff @(posedge mips_cpu_clk or negedge mips_axi_if_resetn) begin
    if (!mips_axi_if_resetn) begin
      wait_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && !req_ready[i]) begin
          wait_cnt_q[i*32 +: 32] <= wait_cnt_q[i*32 +: 32] + 32'd1;
        end
      end
    end
  end

  assign arb_wait_cnt = wait_cnt_q;
`endif

endmodule
